// File: rtl/rf_mp.sv
// rf_mp: multi-port register file with sync write, comb reads, bypass, zero reg and clear sweep
module rf_mp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_err
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] store [DEPTH];
  logic wr_acc;
  assign busy = (state == CLEAR);
  assign wr_acc = !rst && !busy && !clr_req && wr_en && !((ZERO_REG != 0) && wr_addr == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && (busy || clr_req);
      if (busy) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (clr_ptr == '1) state <= IDLE;
      end else if (clr_req) begin
        state <= CLEAR;
        clr_ptr <= '0;
      end
    end
  end
  // storage has no reset; only the sweep zeroes it
  always_ff @(posedge clk) begin
    if (busy) store[clr_ptr] <= '0;
    else if (wr_acc) store[wr_addr] <= wr_data;
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_data[i*DATA_W +: DATA_W] = busy ? '0 :
                                         ((ZERO_REG != 0) && ra == '0) ? '0 :
                                         ((BYPASS != 0) && wr_acc && ra == wr_addr) ? wr_data :
                                         store[ra];
  end
endmodule

// File: tb/tb_rf_mp.sv
// tb_rf_mp: directed checks of rf_mp across bypass, no-bypass and zero-reg variants
module tb_rf_mp;
  logic clk = 1'b0;
  logic rst, wr_en, clr_req;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [15:0] rd1, rd0, rdz;
  logic b1, b0, bz, e1, e0, ez;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_mp #(.BYPASS(1), .ZERO_REG(0)) d1 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd1), .clr_req(clr_req), .busy(b1), .wr_err(e1));
  rf_mp #(.BYPASS(0), .ZERO_REG(0)) d0 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd0), .clr_req(clr_req), .busy(b0), .wr_err(e0));
  rf_mp #(.BYPASS(1), .ZERO_REG(1)) dz (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rdz), .clr_req(clr_req), .busy(bz), .wr_err(ez));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; clr_req = 1'b0;
    wr_addr = 4'd0; wr_data = 8'h00; rd_addr = {4'd15, 4'd5};
    tick; tick;
    chk("rst_busy", {b1, b0, bz}, 3'b111);
    chk("rst_werr", {e1, e0, ez}, 3'b000);
    chk("rst_rd", {rd1, rd0, rdz}, 48'h0);
    rst = 1'b0; #1;
    for (int k = 0; k < 16; k++) begin
      chk("sweep_busy", {b1, b0, bz}, 3'b111);
      chk("sweep_rd", {rd1, rd0, rdz}, 48'h0);
      tick;
    end
    chk("sweep_done", {b1, b0, bz}, 3'b000);
    chk("clr_5_15", {rd1, rd0, rdz}, 48'h0);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5; rd_addr = {4'd3, 4'd3}; #1;
    chk("nb_old", rd0, 48'h0000);
    chk("byp_a5", rd1, 48'hA5A5);
    tick; wr_en = 1'b0; #1;
    chk("nb_new", rd0, 48'hA5A5);
    chk("werr_ok", {e1, e0, ez}, 3'b000);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C; rd_addr = {4'd7, 4'd3}; #1;
    chk("byp_3c", rd1, 48'h3CA5);
    chk("nb_3c_old", rd0, 48'h00A5);
    tick; wr_en = 1'b0; #1;
    chk("nb_3c", rd0, 48'h3CA5);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h11; rd_addr = {4'd9, 4'd9};
    tick; wr_data = 8'h22; #1;
    chk("b2b_first", rd0, 48'h1111);
    tick; wr_en = 1'b0; #1;
    chk("b2b_last", {rd0, rd1}, 48'h22222222);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h55; rd_addr = {4'd0, 4'd0}; #1;
    chk("z_byp0", rdz, 48'h0);
    chk("nz_byp0", rd1, 48'h5555);
    tick; wr_en = 1'b0; #1;
    chk("z_rd0", rdz, 48'h0);
    chk("z_werr0", ez, 1'b0);
    chk("nz_rd0", rd0, 48'h5555);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h55; rd_addr = {4'd0, 4'd1}; #1;
    chk("z_byp1", rdz, 48'h0055);
    tick; wr_en = 1'b0; #1;
    chk("z_rd1", rdz, 48'h0055);
    chk("z_werr1", ez, 1'b0);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'hFF; rd_addr = {4'd2, 4'd2}; #1;
    chk("col_pre", rd1, 48'h0);
    tick; clr_req = 1'b0; wr_addr = 4'd3; wr_data = 8'h77; #1;
    chk("col_werr", {e1, e0, ez}, 3'b111);
    chk("col_busy", {b1, b0, bz}, 3'b111);
    for (int k = 1; k < 16; k++) begin
      clr_req = (k == 4);
      tick;
      chk("busy_wr_busy", {b1, b0, bz}, 3'b111);
      chk("busy_wr_werr", {e1, e0, ez}, 3'b111);
      chk("busy_wr_rd", {rd1, rd0, rdz}, 48'h0);
    end
    wr_en = 1'b0;
    tick;
    chk("col_done", {b1, b0, bz}, 3'b000);
    chk("col_werr_end", {e1, e0, ez}, 3'b000);
    rd_addr = {4'd3, 4'd2}; #1;
    chk("col_rd", {rd1, rd0}, 48'h0);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h99;
    tick; wr_en = 1'b0; rd_addr = {4'd4, 4'd4}; #1;
    chk("pre_mid", rd0, 48'h9999);
    clr_req = 1'b1;
    tick; clr_req = 1'b0;
    for (int k = 0; k < 8; k++) tick;
    chk("mid_busy9", {b1, b0, bz}, 3'b111);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'hEE;
    tick; rst = 1'b0; #1;
    chk("mid_rst_busy", {b1, b0, bz}, 3'b111);
    chk("mid_rst_werr", {e1, e0, ez}, 3'b000);
    for (int k = 0; k < 16; k++) begin
      chk("mid_busy", {b1, b0, bz}, 3'b111);
      chk("mid_rd", {rd1, rd0, rdz}, 48'h0);
      tick;
      chk("mid_werr", {e1, e0, ez}, 3'b111);
    end
    chk("mid_done", {b1, b0, bz}, 3'b000);
    wr_en = 1'b0; #1;
    chk("mid_rd4", {rd1, rd0, rdz}, 48'h0);
    tick;
    chk("mid_werr_end", {e1, e0, ez}, 3'b000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
